i2s_tx_slave: RTL and testbench

- Serializes 16-bit stereo PCM frames onto the codec DAC serial line in standard I2S format.
- Bit clock and word clock are supplied by the codec. The block is a slave on the same bclk/lrck pair used by the ADC receive path.
- Sits downstream of the denoise datapath. Accepts one stereo frame per lrck period via a valid/ready handshake into a one-frame holding buffer.

---
 rtl/i2s_tx_slave.sv | 81 ++++++++
 tb/tb_i2s_tx_slave.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_slave.sv
// i2s_tx_slave: I2S slave transmitter that serializes stereo PCM frames onto the DAC line, MSB first.
// Frames wait in a one-deep holding buffer and load into the shifter at each left-slot start.
module i2s_tx_slave #(
    parameter int DW = 16,
    parameter int UNDERRUN_REPEAT = 0
) (
    input  logic          bclk,
    input  logic          rst,
    input  logic          lrck_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_l_i,
    input  logic [DW-1:0] in_r_i,
    output logic          in_ready_o,
    output logic          sdata_o,
    output logic          frame_start_o,
    output logic          underrun_o,
    output logic [15:0]   underrun_cnt_o
);
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);
    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
    state_t        state_q;
    logic          lrck_q, hold_full_q;
    logic [DW-1:0] hold_l_q, hold_r_q, active_l_q, active_r_q, shreg_q;
    logic [CW-1:0] bit_cnt_q;
    logic          fall, rise;
    assign fall = lrck_q & ~lrck_i;
    assign rise = ~lrck_q & lrck_i;
    assign in_ready_o = ~hold_full_q;
    always_ff @(posedge bclk) begin
        if (rst) begin
            state_q        <= SYNC;
            lrck_q         <= 1'b0;
            hold_full_q    <= 1'b0;
            hold_l_q       <= '0;
            hold_r_q       <= '0;
            active_l_q     <= '0;
            active_r_q     <= '0;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            frame_start_o  <= 1'b0;
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
        end else begin
            lrck_q        <= lrck_i;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
            if (in_valid_i && !hold_full_q) begin
                hold_l_q    <= in_l_i;
                hold_r_q    <= in_r_i;
                hold_full_q <= 1'b1;
            end
            // The buffer is sampled before this edge's acceptance, so a same-edge frame waits a period.
            if (fall) begin
                state_q       <= LEFT;
                frame_start_o <= 1'b1;
                bit_cnt_q     <= LAST;
                if (hold_full_q) begin
                    active_l_q  <= hold_l_q;
                    active_r_q  <= hold_r_q;
                    hold_full_q <= 1'b0;
                    shreg_q     <= hold_l_q;
                end else begin
                    underrun_o <= 1'b1;
                    underrun_cnt_o <= (underrun_cnt_o != 16'hFFFF) ? underrun_cnt_o + 1'b1 : underrun_cnt_o;
                    shreg_q    <= (UNDERRUN_REPEAT != 0) ? active_l_q : '0;
                    active_r_q <= (UNDERRUN_REPEAT != 0) ? active_r_q : '0;
                end
            end else if (rise && state_q != SYNC) begin
                state_q   <= RIGHT;
                shreg_q   <= active_r_q;
                bit_cnt_q <= LAST;
            end else if (state_q != SYNC) begin
                shreg_q   <= {shreg_q[DW-2:0], 1'b0};
                bit_cnt_q <= (bit_cnt_q != '0) ? bit_cnt_q - 1'b1 : bit_cnt_q;
            end
        end
    end
    // Driving on the falling edge gives the one-bit I2S delay after each lrck transition.
    always_ff @(negedge bclk) sdata_o <= rst ? 1'b0 : shreg_q[DW-1];
endmodule

// File: tb/tb_i2s_tx_slave.sv
// tb_i2s_tx_slave: scoreboard bench driving two transmitters (zero-fill and repeat underrun policies)
// with one shared codec clock/word-select and deserializing both serial lines.
module tb_i2s_tx_slave;
    localparam int DW = 16;
    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        bit          ur;
        bit          skip;
    } slot_t;

    logic        bclk = 1'b0;
    logic        rst, lrck, in_valid;
    logic [15:0] in_l, in_r;
    logic        rdy0, rdy1, sd0, sd1, fs0, fs1, ur0, ur1;
    logic [15:0] cnt0, cnt1;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          cur_v = 1'b0;
    slot_t       cur;
    slot_t       exq[$];
    logic [31:0] feed[$];

    i2s_tx_slave #(.DW(DW), .UNDERRUN_REPEAT(0)) dut0 (
        .bclk(bclk), .rst(rst), .lrck_i(lrck), .in_valid_i(in_valid), .in_l_i(in_l), .in_r_i(in_r),
        .in_ready_o(rdy0), .sdata_o(sd0), .frame_start_o(fs0), .underrun_o(ur0), .underrun_cnt_o(cnt0)
    );
    i2s_tx_slave #(.DW(DW), .UNDERRUN_REPEAT(1)) dut1 (
        .bclk(bclk), .rst(rst), .lrck_i(lrck), .in_valid_i(in_valid), .in_l_i(in_l), .in_r_i(in_r),
        .in_ready_o(rdy1), .sdata_o(sd1), .frame_start_o(fs1), .underrun_o(ur1), .underrun_cnt_o(cnt1)
    );

    always #5 bclk = ~bclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic slot(input logic lv, input int n, input logic [15:0] e0, input logic [15:0] e1,
                        input bit ur, input bit skip);
        slot_t s;
        s = '{e0, e1, ur, skip};
        exq.push_back(s);
        lrck = lv;
        repeat (n) @(negedge bclk);
    endtask

    // Upstream source: presents the queue head and retires it when the accepting edge is due.
    initial begin
        bit chk_nxt;
        chk_nxt = 1'b0;
        forever begin
            @(negedge bclk);
            if (chk_nxt) begin
                chk("rdy_after_acc0", rdy0, 0);
                chk("rdy_after_acc1", rdy1, 0);
            end
            chk_nxt = 1'b0;
            if (feed.size() == 0) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                {in_l, in_r} = feed[0];
                if (rdy0 && !rst) begin
                    void'(feed.pop_front());
                    chk_nxt = 1'b1;
                end
            end
        end
    end

    // Receiver: bit 1 of a slot is sampled one posedge after the slot-start posedge.
    initial begin
        logic        prev, st;
        int          pos, z0, z1;
        logic [15:0] a0, a1, m;
        prev = 1'b1; pos = 0; z0 = 0; z1 = 0; a0 = '0; a1 = '0;
        forever begin
            @(posedge bclk);
            #1;
            if (cur_v) begin
                if (pos <= DW) begin
                    a0[DW-pos] = sd0;
                    a1[DW-pos] = sd1;
                end else begin
                    z0 += int'(sd0);
                    z1 += int'(sd1);
                end
                pos++;
            end
            st = (lrck != prev);
            prev = lrck;
            if (mon_en && st && cur_v && !cur.skip) begin
                m = (pos - 1 >= DW) ? 16'hFFFF : ~(16'hFFFF >> (pos - 1));
                chk("word0", a0 & m, cur.w0 & m);
                chk("word1", a1 & m, cur.w1 & m);
                chk("tail0", z0, 0);
                chk("tail1", z1, 0);
            end
            if (mon_en && st) begin
                cur_v = exq.size() > 0;
                if (cur_v) cur = exq.pop_front();
                pos = 1; a0 = '0; a1 = '0; z0 = 0; z1 = 0;
            end
            if (mon_en) begin
                chk("fs0", fs0, st & ~lrck);
                chk("fs1", fs1, st & ~lrck);
                chk("ur0", ur0, st & ~lrck & cur_v & cur.ur);
                chk("ur1", ur1, st & ~lrck & cur_v & cur.ur);
                if (st && !lrck) chk("rdy_at_fall", rdy0, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; lrck = 1'b1; in_valid = 1'b0; in_l = '0; in_r = '0;
        @(negedge bclk);
        repeat (100) begin
            @(posedge bclk);
            #1;
            chk("rst_sdata", sd0 | sd1, 0);
            chk("rst_fs", fs0 | fs1, 0);
            chk("rst_rdy", rdy0 & rdy1, 1);
            chk("rst_cnt", cnt0 | cnt1, 0);
        end
        @(negedge bclk);
        rst = 1'b0;
        feed.push_back({16'hA5C3, 16'h1234});
        repeat (8) begin
            @(posedge bclk);
            #1;
            chk("sync_sdata", sd0 | sd1, 0);
            chk("sync_fs", fs0 | fs1, 0);
        end
        chk("sync_held", rdy0, 0);
        @(negedge bclk);
        mon_en = 1'b1;
        slot(0, 32, 16'hA5C3, 16'hA5C3, 0, 0);
        feed.push_back({16'h0001, 16'h8001});
        feed.push_back({16'h0002, 16'h8002});
        feed.push_back({16'h0003, 16'h8003});
        slot(1, 32, 16'h1234, 16'h1234, 0, 0);
        chk("cnt_none", cnt0, 0);
        slot(0, 32, 16'h0001, 16'h0001, 0, 0);
        slot(1, 32, 16'h8001, 16'h8001, 0, 0);
        slot(0, 32, 16'h0002, 16'h0002, 0, 0);
        slot(1, 32, 16'h8002, 16'h8002, 0, 0);
        slot(0, 32, 16'h0003, 16'h0003, 0, 0);
        slot(1, 32, 16'h8003, 16'h8003, 0, 0);
        slot(0, 32, 16'h0000, 16'h0003, 1, 0);
        chk("cnt_ur0", cnt0, 1);
        chk("cnt_ur1", cnt1, 1);
        feed.push_back({16'hFFF0, 16'h0F0F});
        slot(1, 32, 16'h0000, 16'h8003, 0, 0);
        slot(0, 12, 16'hFFF0, 16'hFFF0, 0, 0);
        feed.push_back({16'h5A5A, 16'hC3C3});
        slot(1, 12, 16'h0F0F, 16'h0F0F, 0, 0);
        slot(0, 32, 16'h5A5A, 16'h5A5A, 0, 0);
        feed.push_back({16'h7777, 16'h1111});
        // Right slot cut short by a reset while the 0x7777 frame sits in the buffer.
        exq.push_back('{16'h0000, 16'h0000, 1'b0, 1'b1});
        lrck = 1'b1;
        repeat (10) @(negedge bclk);
        chk("rdy_hold", rdy0, 0);
        rst = 1'b1;
        @(negedge bclk);
        #1;
        chk("rst_mid_sdata0", sd0, 0);
        chk("rst_mid_sdata1", sd1, 0);
        @(negedge bclk);
        rst = 1'b0;
        #1;
        chk("rst_mid_rdy0", rdy0, 1);
        chk("rst_mid_rdy1", rdy1, 1);
        chk("rst_mid_cnt0", cnt0, 0);
        chk("rst_mid_cnt1", cnt1, 0);
        feed.push_back({16'h1357, 16'h2468});
        repeat (20) begin
            @(posedge bclk);
            #1;
            chk("resync_sdata", sd0 | sd1, 0);
        end
        @(negedge bclk);
        slot(0, 32, 16'h1357, 16'h1357, 0, 0);
        slot(1, 32, 16'h2468, 16'h2468, 0, 0);
        slot(0, 4, 16'h0000, 16'h0000, 1, 1);
        chk("cnt_end0", cnt0, 1);
        chk("cnt_end1", cnt1, 1);
        mon_en = 1'b0;
        chk("exq_drained", exq.size(), 0);
        chk("feed_drained", feed.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
